// File: rtl/ddr3_pkg.sv
// Shared types and defaults for the DDR3 read/write arbiter.
// Holds the FSM encoding, default burst/frame geometry and an address helper.
package ddr3_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_CMD   = 2'd2,
    RD_DATA  = 2'd3
  } state_t;

  localparam int AW              = 25;
  localparam int DEF_BURST_LEN   = 64;
  localparam int DEF_FRAME_WORDS = 115200;
  localparam int DEF_BANK_STRIDE = 4194304;
  localparam int DEF_RD_LOW      = 192;

  function automatic logic [AW-1:0] bank_addr(
    input logic          bank,
    input logic [AW-1:0] addr,
    input logic [AW-1:0] stride
  );
    return (bank ? stride : '0) + addr;
  endfunction

endpackage

// File: rtl/frame_addr_gen.sv
// Word-address and bank tracker for one side of the frame buffer.
// Steps by one burst, wraps at frame end and then toggles or loads its bank.
module frame_addr_gen
  import ddr3_pkg::*;
#(
  parameter int BURST_LEN   = DEF_BURST_LEN,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS,
  parameter bit TOGGLE      = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          adv,
  input  logic          clr,
  input  logic          bank_in,
  output logic [AW-1:0] addr,
  output logic          bank,
  output logic          wrap
);

  localparam logic [AW-1:0] STEP = AW'(BURST_LEN);
  localparam logic [AW-1:0] FW   = AW'(FRAME_WORDS);

  logic [AW-1:0] addr_q, addr_d, nxt;
  logic          bank_q, bank_d;

  // next address: advance, wrap at frame end, or restart the frame
  always_comb begin
    nxt    = addr_q + STEP;
    wrap   = adv && (nxt == FW);
    addr_d = addr_q;
    bank_d = bank_q;
    if (clr) begin
      addr_d = '0;
    end else if (wrap) begin
      addr_d = '0;
      bank_d = TOGGLE ? ~bank_q : bank_in;
    end else if (adv) begin
      addr_d = nxt;
    end
  end

  // address/bank state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= '0;
      bank_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      bank_q <= bank_d;
    end
  end

  assign addr = addr_q;
  assign bank = bank_q;

endmodule

// File: rtl/ddr3_rw_arbiter.sv
// Round-robin arbiter between camera write bursts and HDMI read bursts.
// Double-buffers frames across two DDR3 banks so display never reads the live bank.
module ddr3_rw_arbiter
  import ddr3_pkg::*;
#(
  parameter int BURST_LEN   = DEF_BURST_LEN,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int RD_LOW      = DEF_RD_LOW,
  parameter int BANK_STRIDE = DEF_BANK_STRIDE
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         init_done,
  input  logic         wr_frame_start,
  input  logic [9:0]   wr_fifo_usedw,
  input  logic [127:0] wr_fifo_rdata,
  output logic         wr_fifo_rdreq,
  input  logic [9:0]   rd_fifo_usedw,
  output logic         rd_fifo_wrreq,
  output logic [127:0] rd_fifo_wdata,
  output logic [24:0]  avm_address,
  output logic [7:0]   avm_burstcount,
  output logic         avm_write,
  output logic [127:0] avm_writedata,
  output logic         avm_read,
  input  logic         avm_waitrequest,
  input  logic [127:0] avm_readdata,
  input  logic         avm_readdatavalid
);

  localparam logic [9:0]    BL10   = 10'(BURST_LEN);
  localparam logic [9:0]    LOW10  = 10'(RD_LOW);
  localparam logic [7:0]    BC     = 8'(BURST_LEN);
  localparam logic [7:0]    LAST   = 8'(BURST_LEN - 1);
  localparam logic [AW-1:0] STRIDE = AW'(BANK_STRIDE);

  state_t        state_q, state_d;
  logic          write_q, write_d;
  logic          read_q, read_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    bc_q, bc_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          last_wr_q, last_wr_d;
  logic          pend_q, pend_d;
  logic          rd_valid_q, rd_valid_d;
  logic          rd_next_q, rd_next_d;

  logic          wr_adv, wr_clr, rd_adv;
  logic          wr_wrap, rd_wrap;
  logic          wr_bank, rd_bank;
  logic [AW-1:0] wr_addr, rd_addr;
  logic          wr_want, rd_want;

  frame_addr_gen #(
    .BURST_LEN(BURST_LEN), .FRAME_WORDS(FRAME_WORDS), .TOGGLE(1'b1)
  ) u_wr_gen (
    .clk(clk), .rst_n(rst_n), .adv(wr_adv), .clr(wr_clr),
    .bank_in(1'b0), .addr(wr_addr), .bank(wr_bank), .wrap(wr_wrap)
  );

  frame_addr_gen #(
    .BURST_LEN(BURST_LEN), .FRAME_WORDS(FRAME_WORDS), .TOGGLE(1'b0)
  ) u_rd_gen (
    .clk(clk), .rst_n(rst_n), .adv(rd_adv), .clr(1'b0),
    .bank_in(rd_next_q), .addr(rd_addr), .bank(rd_bank), .wrap(rd_wrap)
  );

  assign wr_want = wr_fifo_usedw >= BL10;
  assign rd_want = rd_valid_q && (rd_fifo_usedw <= LOW10);

  // arbitration, burst sequencing and frame-start handling
  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    read_d     = read_q;
    addr_d     = addr_q;
    bc_d       = bc_q;
    cnt_d      = cnt_q;
    last_wr_d  = last_wr_q;
    pend_d     = pend_q | wr_frame_start;
    rd_valid_d = rd_valid_q | wr_wrap;
    rd_next_d  = wr_wrap ? wr_bank : rd_next_q;
    wr_adv     = 1'b0;
    wr_clr     = 1'b0;
    rd_adv     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pend_q) begin
          wr_clr = (wr_addr != '0);
          pend_d = wr_frame_start;
        end else if (init_done && wr_want && (!rd_want || !last_wr_q)) begin
          state_d   = WR_BURST;
          write_d   = 1'b1;
          addr_d    = bank_addr(wr_bank, wr_addr, STRIDE);
          bc_d      = BC;
          cnt_d     = '0;
          last_wr_d = 1'b1;
        end else if (init_done && rd_want) begin
          state_d   = RD_CMD;
          read_d    = 1'b1;
          addr_d    = bank_addr(rd_bank, rd_addr, STRIDE);
          bc_d      = BC;
          cnt_d     = '0;
          last_wr_d = 1'b0;
        end
      end
      WR_BURST: begin
        if (!avm_waitrequest) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == LAST) begin
            write_d = 1'b0;
            wr_adv  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      RD_CMD: begin
        if (!avm_waitrequest) begin
          read_d  = 1'b0;
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (avm_readdatavalid) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == LAST) begin
            rd_adv  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and registered bus outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      write_q    <= 1'b0;
      read_q     <= 1'b0;
      addr_q     <= '0;
      bc_q       <= '0;
      cnt_q      <= '0;
      last_wr_q  <= 1'b0;
      pend_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_next_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      read_q     <= read_d;
      addr_q     <= addr_d;
      bc_q       <= bc_d;
      cnt_q      <= cnt_d;
      last_wr_q  <= last_wr_d;
      pend_q     <= pend_d;
      rd_valid_q <= rd_valid_d;
      rd_next_q  <= rd_next_d;
    end
  end

  assign avm_write      = write_q;
  assign avm_read       = read_q;
  assign avm_address    = addr_q;
  assign avm_burstcount = bc_q;
  assign avm_writedata  = wr_fifo_rdata;
  assign wr_fifo_rdreq  = write_q & ~avm_waitrequest;
  assign rd_fifo_wrreq  = avm_readdatavalid;
  assign rd_fifo_wdata  = avm_readdata;

endmodule
